// File: rtl/ghash_stream_if.sv
// ghash_stream_if: key load, input FIFO pop and output FIFO push bundle.
// slave = GHASH engine side, master = producer/consumer side.
interface ghash_stream_if;
   logic [127:0] hKey;
   logic         keyReady;
   logic         keyUsed;
   logic         rxEmpty;
   logic [127:0] rxData;
   logic         rxLast;
   logic         rxPop;
   logic         txFull;
   logic [127:0] txData;
   logic         txPush;
   logic         busy;

   modport slave (
      input  hKey, keyReady, rxEmpty, rxData, rxLast, txFull,
      output keyUsed, rxPop, txData, txPush, busy
   );

   modport master (
      output hKey, keyReady, rxEmpty, rxData, rxLast, txFull,
      input  keyUsed, rxPop, txData, txPush, busy
   );
endinterface

// File: rtl/ghash_stream.sv
// ghash_stream: digit-serial GHASH, Y_i = (Y_{i-1} ^ X_i) * H in GF(2^128).
// Ports: clk, rst (async, active high), gs (key / rx pop / tx push bundle).
module ghash_stream #(
   parameter int DIGIT = 8
) (
   input  logic           clk,
   input  logic           rst,
   ghash_stream_if.slave  gs
);

   localparam int NDIG = 128 / DIGIT;
   localparam logic [7:0] CNT_LAST = 8'(NDIG - 1);
   // Reduction constant in GCM bit order (bit 127 = x^0).
   localparam logic [127:0] R = {8'he1, 120'd0};
   localparam bit LEGAL = (DIGIT == 1) || (DIGIT == 2) ||
                          (DIGIT == 4) || (DIGIT == 8) ||
                          (DIGIT == 16) || (DIGIT == 32) ||
                          (DIGIT == 64) || (DIGIT == 128);

   if (!LEGAL) begin : g_bad_digit
      $error("ghash_stream: illegal DIGIT %0d", DIGIT);
   end

   typedef enum logic [1:0] {
      NOKEY,
      READY,
      MULT,
      OUT
   } state_t;

   state_t state, state_nx;

   logic [127:0] h, y, z, v, x, tx_data;
   logic [127:0] z_nx, v_nx;
   logic [7:0]   cnt;
   logic         last, busy_q;
   logic         key_ld, pop, push, fin;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= NOKEY;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      key_ld   = 1'b0;
      pop      = 1'b0;
      push     = 1'b0;
      fin      = (cnt == CNT_LAST);
      unique case (state)
         NOKEY: begin
            if (gs.keyReady) begin
               key_ld   = 1'b1;
               state_nx = READY;
            end
         end
         READY: begin
            // A pending key wins over a pending block.
            if (gs.keyReady) begin
               key_ld = 1'b1;
            end else if (!gs.rxEmpty) begin
               pop      = 1'b1;
               state_nx = MULT;
            end
         end
         MULT: begin
            if (fin) state_nx = last ? OUT : READY;
         end
         OUT: begin
            if (!gs.txFull) begin
               push     = 1'b1;
               state_nx = READY;
            end
         end
         default: state_nx = NOKEY;
      endcase
   end

   // DIGIT bits of X per cycle, x^0 coefficient first.
   always_comb begin
      z_nx = z;
      v_nx = v;
      for (int j = 0; j < DIGIT; j++) begin
         if (x[127-j]) z_nx = z_nx ^ v_nx;
         v_nx = v_nx[0] ? ((v_nx >> 1) ^ R) : (v_nx >> 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h       <= '0;
         y       <= '0;
         z       <= '0;
         v       <= '0;
         x       <= '0;
         cnt     <= '0;
         last    <= 1'b0;
         tx_data <= '0;
         busy_q  <= 1'b0;
      end else begin
         if (key_ld) h <= gs.hKey;
         if (pop) begin
            x      <= y ^ gs.rxData;
            last   <= gs.rxLast;
            z      <= '0;
            v      <= h;
            cnt    <= '0;
            busy_q <= 1'b1;
         end
         if (state == MULT) begin
            z   <= z_nx;
            v   <= v_nx;
            x   <= x << DIGIT;
            cnt <= cnt + 8'd1;
            if (fin) begin
               y <= z_nx;
               // Result is presented for the whole OUT wait.
               if (last) tx_data <= z_nx;
            end
         end
         if (push) begin
            y      <= '0;
            busy_q <= 1'b0;
         end
      end
   end

   assign gs.keyUsed = key_ld & ~rst;
   assign gs.rxPop   = pop & ~rst;
   assign gs.txPush  = push & ~rst;
   assign gs.txData  = tx_data;
   assign gs.busy    = busy_q;

endmodule

// File: tb/tb_ghash_stream.sv
// tb_ghash_stream: randomized and directed checks of ghash_stream
// against a carry-less multiply + polynomial reduction model.
module tb_ghash_stream;

   localparam int DIGIT = 8;
   localparam int NDIG  = 128 / DIGIT;

   localparam logic [127:0] HK   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] ONE  = 128'h80000000000000000000000000000000;
   localparam logic [127:0] B0   = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] B1   = 128'h00000000000000000000000000000080;
   localparam logic [127:0] Y1   = 128'h5e2ec746917062882c85b0685353deb7;
   localparam logic [127:0] TAG2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [127:0] cur_h;
   logic [127:0] q[$];

   ghash_stream_if gs();

   ghash_stream #(.DIGIT(DIGIT)) dut (
      .clk (clk),
      .rst (rst),
      .gs  (gs)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // GCM bit order: bit 127-k holds the x^k coefficient.
   function automatic logic [127:0] gmul(input logic [127:0] a,
                                         input logic [127:0] b);
      logic [254:0] p;
      logic [127:0] r;
      p = '0;
      for (int i = 0; i < 128; i++)
         if (a[127-i])
            for (int j = 0; j < 128; j++)
               if (b[127-j]) p[i+j] = ~p[i+j];
      // x^128 = x^7 + x^2 + x + 1
      for (int k = 254; k >= 128; k--)
         if (p[k]) begin
            p[k]     = 1'b0;
            p[k-128] = ~p[k-128];
            p[k-127] = ~p[k-127];
            p[k-126] = ~p[k-126];
            p[k-121] = ~p[k-121];
         end
      for (int k = 0; k < 128; k++) r[127-k] = p[k];
      return r;
   endfunction

   function automatic logic [127:0] ghash(input logic [127:0] k,
                                          input logic [127:0] b[$]);
      logic [127:0] y;
      y = '0;
      foreach (b[i]) y = gmul(y ^ b[i], k);
      return y;
   endfunction

   task automatic load_key(input logic [127:0] k, input bit with_data);
      gs.hKey     = k;
      gs.keyReady = 1'b1;
      gs.rxEmpty  = !with_data;
      gs.rxData   = 128'h1234;
      gs.rxLast   = 1'b1;
      @(negedge clk);
      check("key_used", {127'd0, gs.keyUsed}, 128'd1);
      if (with_data) check("key_nopop", {127'd0, gs.rxPop}, 128'd0);
      tick();
      gs.keyReady = 1'b0;
      gs.rxEmpty  = 1'b1;
      cur_h       = k;
   endtask

   task automatic run_msg(input string tag, input logic [127:0] blks[$],
                          input logic [127:0] exp, input int stall,
                          input bit kpulse);
      int i, t, t_pop, since, lat, bad, prev_pop;
      bit done, tail;
      logic [127:0] got, held;
      i = 0; t = 0; t_pop = -1; lat = -1; bad = 0; prev_pop = -1000;
      done = 1'b0; got = 'x; held = '0;
      while (!done && t < 4000) begin
         tail  = (i == blks.size());
         since = tail ? t - t_pop : -1;
         // Data stays offered during a stall to probe for stray pops.
         gs.rxEmpty  = tail ? (stall == 0) : 1'b0;
         gs.rxData   = tail ? 128'hdeadbeef : blks[i];
         gs.rxLast   = (i == blks.size() - 1);
         gs.txFull   = tail && (since <= NDIG + stall);
         gs.keyReady = kpulse && tail && (since == 2);
         gs.hKey     = gs.keyReady ? ~cur_h : cur_h;
         @(negedge clk);
         if (gs.keyUsed) bad++;
         if (tail && !gs.busy) bad++;
         if (gs.rxPop) begin
            if (tail || gs.rxEmpty) bad++;
            if (t - prev_pop < NDIG + 1) bad++;
            prev_pop = t;
            i++;
            if (i == blks.size()) t_pop = t;
         end
         if (tail && since > NDIG && since <= NDIG + stall) begin
            if (since == NDIG + 1) held = gs.txData;
            else if (gs.txData !== held) bad++;
            if (gs.txPush) bad++;
         end
         if (gs.txPush) begin
            if (!tail) bad++;
            got  = gs.txData;
            lat  = since;
            done = 1'b1;
         end
         tick();
         t++;
      end
      gs.keyReady = 1'b0;
      gs.hKey     = cur_h;
      gs.txFull   = 1'b0;
      gs.rxEmpty  = 1'b1;
      check({tag, "_res"}, got, exp);
      check({tag, "_lat"}, 128'(lat), 128'(NDIG + 1 + stall));
      check({tag, "_proto"}, 128'(bad), 128'd0);
   endtask

   initial begin
      int pops, n;
      logic [127:0] k, e;
      rst         = 1'b1;
      gs.hKey     = '0;
      gs.keyReady = 1'b0;
      gs.rxEmpty  = 1'b1;
      gs.rxData   = '0;
      gs.rxLast   = 1'b0;
      gs.txFull   = 1'b0;
      cur_h       = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ctl", {124'd0, gs.keyUsed, gs.rxPop, gs.txPush, gs.busy},
            128'd0);
      check("rst_txdata", gs.txData, 128'd0);
      tick();
      rst = 1'b0;

      // No key yet: offered data must not be popped.
      pops = 0;
      gs.rxEmpty = 1'b0;
      gs.rxData  = B0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (gs.rxPop) pops++;
         tick();
      end
      gs.rxEmpty = 1'b1;
      check("nokey_pop", 128'(pops), 128'd0);

      load_key(HK, 1'b0);
      load_key(HK, 1'b1);

      q.delete(); q.push_back(ONE);
      run_msg("ident", q, HK, 0, 1'b0);

      q.delete(); q.push_back(B0);
      run_msg("tc2_y1", q, Y1, 0, 1'b0);

      q.delete(); q.push_back(B0); q.push_back(B1);
      check("model_tc2", ghash(HK, q), TAG2);
      run_msg("tc2", q, TAG2, 0, 1'b0);

      q.delete(); q.push_back('0);
      run_msg("zero", q, '0, 0, 1'b0);
      q.delete(); q.push_back(ONE);
      run_msg("ident2", q, HK, 0, 1'b0);

      q.delete(); q.push_back(B0); q.push_back(B1);
      run_msg("stall", q, TAG2, 20, 1'b0);
      run_msg("keymult", q, TAG2, 0, 1'b1);

      // Reset in the middle of the first block's multiply.
      gs.rxEmpty = 1'b0;
      gs.rxData  = B0;
      gs.rxLast  = 1'b0;
      pops = 0;
      for (int c = 0; c < 50 && pops == 0; c++) begin
         @(negedge clk);
         if (gs.rxPop) pops++;
         tick();
      end
      check("mid_pop", 128'(pops), 128'd1);
      gs.rxEmpty = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_ctl", {124'd0, gs.keyUsed, gs.rxPop, gs.txPush, gs.busy},
            128'd0);
      check("mid_rst_txdata", gs.txData, 128'd0);
      tick();
      rst = 1'b0;
      pops = 0;
      gs.rxEmpty = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (gs.rxPop) pops++;
         tick();
      end
      gs.rxEmpty = 1'b1;
      check("mid_nokey_pop", 128'(pops), 128'd0);
      load_key(HK, 1'b0);
      q.delete(); q.push_back(B0); q.push_back(B1);
      run_msg("rerun", q, TAG2, 0, 1'b0);

      for (int m = 0; m < 8; m++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         load_key(k, 1'b0);
         n = $urandom_range(1, 4);
         q.delete();
         for (int b = 0; b < n; b++)
            q.push_back({$urandom, $urandom, $urandom, $urandom});
         e = ghash(k, q);
         run_msg($sformatf("rnd%0d", m), q, e, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
